// File: rtl/calc_pkg.sv
// Shared types and constants for the four-function calculator: sequencer
// state encoding, datapath widths, error codes and ALU operator codes.
package calc_pkg;

  localparam int OPND_W = 13;
  localparam int RES_W  = 25;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    LOAD_B  = 3'd2,
    EXEC    = 3'd3,
    SHOW_R  = 3'd4,
    ERR     = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_MEM_OVF = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

endpackage

// File: rtl/calc_timeout_ctr.sv
// Clear/enable cycle counter that saturates at TIMEOUT and flags the terminal
// count; used to bound how long the sequencer waits on the ALU.
module calc_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt != TERM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: key pulses to register-bank load strobes, ALU
// start/done handshake, memory register. Memory feature gated by CALC_MEMORY_EN.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn_op,
  input  logic                     btn_equal,
  input  logic                     btn_clear,
  input  logic                     btn_new,
  input  logic                     btn_mr,
  input  logic                     btn_ms,
  input  logic [3:0]               op_code,
  input  logic signed [RES_W-1:0]  result,
  input  logic                     alu_done,
  output logic                     ld_a,
  output logic                     ld_b,
  output logic                     ld_op,
  output logic                     ld_r,
  output logic                     ld_m,
  output logic                     alu_start,
  output logic signed [OPND_W-1:0] memory,
  output logic                     busy,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [2:0]               state
);

  state_e st;
  logic   tmo;
  logic   unused_inputs;

  // Only the highest-priority key in a cycle acts (clear > equal > op > new > mr > ms).
  logic key_equal, key_op, key_new;
  assign key_equal = btn_equal & ~btn_clear;
  assign key_op    = btn_op & ~(btn_clear | btn_equal);
  assign key_new   = btn_new & ~(btn_clear | btn_equal | btn_op);

`ifdef CALC_MEMORY_EN
  logic                     key_mr, key_ms;
  logic                     b_from_mem;
  logic signed [OPND_W-1:0] mem_q;

  assign key_mr = btn_mr & ~(btn_clear | btn_equal | btn_op | btn_new);
  assign key_ms = btn_ms & ~(btn_clear | btn_equal | btn_op | btn_new | btn_mr);
  assign memory = mem_q;
  assign unused_inputs = ^op_code;

  function automatic logic fits_opnd(input logic signed [RES_W-1:0] v);
    return (&v[RES_W-1:OPND_W-1]) | ~(|v[RES_W-1:OPND_W-1]);
  endfunction
`else
  assign memory = '0;
  assign unused_inputs = ^{op_code, result, btn_mr, btn_ms};
`endif

  calc_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (st == LOAD_B),
    .en    (st == EXEC),
    .tc    (tmo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= ENTER_A;
      ld_a      <= 1'b0;
      ld_b      <= 1'b0;
      ld_op     <= 1'b0;
      ld_r      <= 1'b0;
      ld_m      <= 1'b0;
      alu_start <= 1'b0;
      err_code  <= ERR_NONE;
`ifdef CALC_MEMORY_EN
      mem_q      <= '0;
      b_from_mem <= 1'b0;
`endif
    end else begin
      ld_a      <= 1'b0;
      ld_b      <= 1'b0;
      ld_op     <= 1'b0;
      ld_r      <= 1'b0;
      ld_m      <= 1'b0;
      alu_start <= 1'b0;
      if (btn_clear) begin
        st       <= ENTER_A;
        err_code <= ERR_NONE;
`ifdef CALC_MEMORY_EN
        b_from_mem <= 1'b0;
`endif
      end else begin
        unique case (st)
          ENTER_A: begin
            if (key_op) begin
              ld_a  <= 1'b1;
              ld_op <= 1'b1;
              st    <= ENTER_B;
            end
          end
          ENTER_B: begin
            if (key_equal) begin
              st <= LOAD_B;
`ifdef CALC_MEMORY_EN
              ld_b <= ~b_from_mem;
`else
              ld_b <= 1'b1;
`endif
            end else if (key_op) begin
              ld_op <= 1'b1;
`ifdef CALC_MEMORY_EN
            end else if (key_mr) begin
              ld_m       <= 1'b1;
              b_from_mem <= 1'b1;
`endif
            end
          end
          LOAD_B: begin
            alu_start <= 1'b1;
            st        <= EXEC;
          end
          // Done wins over a coinciding terminal count.
          EXEC: begin
            if (alu_done) begin
              ld_r <= 1'b1;
              st   <= SHOW_R;
            end else if (tmo) begin
              err_code <= ERR_TIMEOUT;
              st       <= ERR;
            end
          end
          SHOW_R: begin
            if (key_new) begin
              st <= ENTER_A;
`ifdef CALC_MEMORY_EN
              b_from_mem <= 1'b0;
            end else if (key_ms) begin
              if (fits_opnd(result)) begin
                mem_q <= result[OPND_W-1:0];
              end else begin
                err_code <= ERR_MEM_OVF;
                st       <= ERR;
              end
`endif
            end
          end
          ERR: ;
          default: st <= ENTER_A;
        endcase
      end
    end
  end

  assign busy  = (st == EXEC);
  assign error = (st == ERR);
  assign state = st;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus random key
// traffic, every cycle compared against a key-event reference model.
`timescale 1ns/1ps
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int TIMEOUT = 16;
`ifdef CALC_MEMORY_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, btn_op, btn_equal, btn_clear, btn_new, btn_mr, btn_ms, alu_done;
  logic [3:0] op_code;
  logic signed [24:0] result;
  logic ld_a, ld_b, ld_op, ld_r, ld_m, alu_start, busy, error;
  logic signed [12:0] memory;
  logic [1:0] err_code;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  calc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .btn_op(btn_op), .btn_equal(btn_equal),
    .btn_clear(btn_clear), .btn_new(btn_new), .btn_mr(btn_mr), .btn_ms(btn_ms),
    .op_code(op_code), .result(result), .alu_done(alu_done),
    .ld_a(ld_a), .ld_b(ld_b), .ld_op(ld_op), .ld_r(ld_r), .ld_m(ld_m),
    .alu_start(alu_start), .memory(memory), .busy(busy), .error(error),
    .err_code(err_code), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: calculator behaviour as seen from the keypad.
  state_e m_st;
  logic m_bfm;
  logic signed [12:0] m_mem;
  logic [1:0] m_err;
  int m_exec_cycles;
  logic e_ld_a, e_ld_b, e_ld_op, e_ld_r, e_ld_m, e_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_step();
    string key;
    int rv;
    {e_ld_a, e_ld_b, e_ld_op, e_ld_r, e_ld_m, e_start} = '0;
    if (!rst_n) begin
      m_st = ENTER_A; m_bfm = 1'b0; m_mem = '0; m_err = 2'd0;
      return;
    end
    if (btn_clear) key = "clear";
    else if (btn_equal) key = "equal";
    else if (btn_op) key = "op";
    else if (btn_new) key = "new";
    else if (btn_mr) key = "mr";
    else if (btn_ms) key = "ms";
    else key = "none";
    if (!MEM_EN && (key == "mr" || key == "ms")) key = "none";

    if (key == "clear") begin
      m_st = ENTER_A; m_err = 2'd0; m_bfm = 1'b0;
      return;
    end
    case (m_st)
      ENTER_A: if (key == "op") begin e_ld_a = 1'b1; e_ld_op = 1'b1; m_st = ENTER_B; end
      ENTER_B: begin
        if (key == "equal") begin e_ld_b = !m_bfm; m_st = LOAD_B; end
        else if (key == "op") e_ld_op = 1'b1;
        else if (key == "mr") begin e_ld_m = 1'b1; m_bfm = 1'b1; end
      end
      LOAD_B: begin e_start = 1'b1; m_exec_cycles = 0; m_st = EXEC; end
      EXEC: begin
        if (alu_done) begin e_ld_r = 1'b1; m_st = SHOW_R; end
        else if (m_exec_cycles == TIMEOUT) begin m_err = 2'd1; m_st = ERR; end
        else m_exec_cycles++;
      end
      SHOW_R: begin
        if (key == "new") begin m_st = ENTER_A; m_bfm = 1'b0; end
        else if (key == "ms") begin
          rv = result;
          if (rv >= -4096 && rv <= 4095) m_mem = result[12:0];
          else begin m_err = 2'd2; m_st = ERR; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("state", 32'(state), 32'(m_st));
    check("strobes", 32'({ld_a, ld_b, ld_op, ld_r, ld_m, alu_start}),
          32'({e_ld_a, e_ld_b, e_ld_op, e_ld_r, e_ld_m, e_start}));
    check("status", 32'({busy, error, err_code}),
          32'({m_st == EXEC, m_st == ERR, m_err}));
    check("memory", 32'(memory), 32'(m_mem));
    {btn_op, btn_equal, btn_clear, btn_new, btn_mr, btn_ms, alu_done} = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    {btn_op, btn_equal, btn_clear, btn_new, btn_mr, btn_ms, alu_done} = '0;
    op_code = 4'd0;
    result = '0;
    m_st = ENTER_A; m_bfm = 1'b0; m_mem = '0; m_err = 2'd0; m_exec_cycles = 0;

    // Reset state
    tick(); tick();
    check("rst_state", 32'(state), 32'(ENTER_A));
    check("rst_outs", 32'({ld_a, ld_b, ld_op, ld_r, ld_m, alu_start, busy, error, err_code}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic calculation
    btn_op = 1'b1; op_code = 4'd2; tick();
    check("basic_ld_a_op", 32'({ld_a, ld_op}), 32'b11);
    tick();
    btn_equal = 1'b1; tick();
    check("basic_ld_b", 32'(ld_b), 32'd1);
    tick();
    check("basic_start", 32'(alu_start), 32'd1);
    tick(); tick();
    alu_done = 1'b1; tick();
    check("basic_ld_r", 32'(ld_r), 32'd1);
    check("basic_show", 32'(state), 32'(SHOW_R));

    // Memory round trip
    result = 25'sd100; btn_ms = 1'b1; tick();
`ifdef CALC_MEMORY_EN
    check("ms_store", 32'(memory), 32'd100);
`else
    check("ms_off", 32'(memory), 32'd0);
`endif
    btn_new = 1'b1; tick();
    btn_op = 1'b1; tick();
    btn_mr = 1'b1; tick();
`ifdef CALC_MEMORY_EN
    check("mr_ld_m", 32'(ld_m), 32'd1);
`else
    check("mr_off_ld_m", 32'(ld_m), 32'd0);
`endif
    btn_equal = 1'b1; tick();
`ifdef CALC_MEMORY_EN
    check("mr_no_ld_b", 32'(ld_b), 32'd0);
`else
    check("mr_off_ld_b", 32'(ld_b), 32'd1);
`endif
    tick();
    alu_done = 1'b1; tick();

    // Overflow store
    result = 25'sd5000; btn_ms = 1'b1; tick();
`ifdef CALC_MEMORY_EN
    check("ovf_err", 32'({error, err_code}), 32'b110);
    check("ovf_mem", 32'(memory), 32'd100);
`else
    check("ovf_off", 32'({error, err_code}), 32'd0);
`endif
    btn_clear = 1'b1; tick();
    check("clr_state", 32'(state), 32'(ENTER_A));

    // ALU timeout
    btn_op = 1'b1; tick();
    btn_equal = 1'b1; tick();
    tick();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (error) begin n = i; break; end
    end
    check("tmo_cycles", 32'(n), 32'd17);
    check("tmo_code", 32'(err_code), 32'd1);
    btn_clear = 1'b1; tick();
    btn_op = 1'b1; tick();
    btn_equal = 1'b1; tick();
    tick();
    repeat (16) tick();
    alu_done = 1'b1; tick();
    check("tmo_edge_ld_r", 32'({ld_r, error}), 32'b10);

    // Simultaneous keys, reset mid-EXEC
    btn_clear = 1'b1; tick();
    btn_op = 1'b1; tick();
    btn_clear = 1'b1; btn_equal = 1'b1; tick();
    check("simul_state", 32'(state), 32'(ENTER_A));
    check("simul_ld_b", 32'(ld_b), 32'd0);
    btn_op = 1'b1; tick();
    btn_equal = 1'b1; tick();
    tick();
    rst_n = 1'b0; alu_done = 1'b1; tick();
    check("rst_exec", 32'({state, ld_r, busy, error, err_code}), 32'd0);
    rst_n = 1'b1; tick();
    check("rst_no_ld_r", 32'(ld_r), 32'd0);

    // Random key traffic
    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 149) != 0);
      btn_clear = ($urandom_range(0, 99) < 3);
      btn_equal = ($urandom_range(0, 99) < 10);
      btn_op    = ($urandom_range(0, 99) < 12);
      btn_new   = ($urandom_range(0, 99) < 10);
      btn_mr    = ($urandom_range(0, 99) < 10);
      btn_ms    = ($urandom_range(0, 99) < 12);
      alu_done  = ($urandom_range(0, 99) < 10);
      op_code   = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) result = 25'($urandom_range(0, 8191)) - 25'd4096;
      else result = 25'($urandom);
      tick();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
